// File: rtl/lenet_buf_pkg.sv
// Shared types and default geometry for the LeNet input ping-pong buffer.
// The geometry constants match the CNN_REAL_* values used by core.
package lenet_buf_pkg;

    localparam int CNN_REAL_W   = 32;
    localparam int CNN_REAL_H   = 32;
    localparam int CNN_REAL_PAD = 2;

    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        FULL,
        READING
    } bank_state_e;

    typedef enum logic {
        RD_IDLE,
        RD_RUN
    } rd_state_e;

endpackage

// File: rtl/lenet_input_buffer_if.sv
// Write bus from core and pixel stream to the CNN, bundled for the buffer.
// slave = the buffer itself, master = the core/CNN side that drives it.
interface lenet_input_buffer_if #(
    parameter int ADDR_W = 10
);
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              wr_en;
    logic              frame_done;
    logic              core_end;
    logic              lenet_doing_signal;
    logic [7:0]        m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;
    logic              overrun;

    modport slave (
        input  wr_addr, wr_data, wr_en, frame_done, core_end, m_ready,
        output lenet_doing_signal, m_data, m_valid, m_last, overrun
    );

    modport master (
        output wr_addr, wr_data, wr_en, frame_done, core_end, m_ready,
        input  lenet_doing_signal, m_data, m_valid, m_last, overrun
    );
endinterface

// File: rtl/lenet_buf_ram.sv
// Simple dual-port pixel RAM holding both banks: one write port and one
// registered read port, written so that it maps onto block RAM.
module lenet_buf_ram #(
    parameter int DEPTH = 2048,
    parameter int AW    = 11,
    parameter int DW    = 8
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);
    logic [DW-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) o_rdata <= r_mem[i_raddr];
    end
endmodule

// File: rtl/lenet_input_buffer.sv
// Two-bank ping-pong frame buffer between core and the LeNet CNN: captures
// padded frames from core and streams them out in raster order.
module lenet_input_buffer
    import lenet_buf_pkg::*;
#(
    parameter int         IMG_W     = CNN_REAL_W,
    parameter int         IMG_H     = CNN_REAL_H,
    parameter int         PAD       = CNN_REAL_PAD,
    parameter logic [7:0] PAD_VALUE = 8'h00,
    parameter int         ADDR_W    = 10
) (
    input  logic                 clk24,
    input  logic                 rst,
    lenet_input_buffer_if.slave  bus
);
    localparam int                NPIX      = IMG_W * IMG_H;
    localparam int unsigned       UW        = IMG_W;
    localparam int unsigned       UH        = IMG_H;
    localparam int unsigned       UP        = PAD;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
    localparam logic [ADDR_W:0]   NPIX_W    = (ADDR_W+1)'(NPIX);

    function automatic logic is_border(input logic [ADDR_W-1:0] a);
        int unsigned row;
        int unsigned col;
        row = 32'(a) / UW;
        col = 32'(a) % UW;
        return (row < UP) || (row >= UH - UP) || (col < UP) || (col >= UW - UP);
    endfunction

    bank_state_e       r_bank_st [2];
    bank_state_e       w_bank_nx [2];
    logic              r_oldest, w_oldest_nx;
    logic              r_capturing, w_cap_nx;
    logic              r_fill_bank, w_fill_nx;
    logic              r_overrun, w_ovr_nx;
    logic              r_doing;
    rd_state_e         r_rd_st, w_rd_st_nx;
    logic [ADDR_W-1:0] r_rd_addr, w_rd_addr_nx;
    logic              r_rd_bank, w_rd_bank_nx;
    logic              w_issue;
    logic [ADDR_W-1:0] w_iss_addr;
    logic              w_iss_bank;
    logic [1:0]        w_avail;
    logic              w_fd, w_we, w_push, w_pop, w_room;
    logic              r_vld_p1, r_pad_p1, r_last_p1;
    logic [7:0]        w_ram_q, w_px_p1;
    logic [1:0]        r_sk_cnt;
    logic [7:0]        r_sk_d [2];
    logic              r_sk_l [2];

    assign w_fd   = bus.frame_done && r_capturing;
    assign w_we   = bus.wr_en && r_capturing && ({1'b0, bus.wr_addr} < NPIX_W);
    assign w_push = r_vld_p1;
    assign w_pop  = (r_sk_cnt != 2'd0) && bus.m_ready;
    // Issue only if the skid still has a slot once the read in flight lands.
    assign w_room = ({1'b0, r_sk_cnt} + {2'b00, r_vld_p1}) <= (3'd1 + {2'b00, w_pop});

    always_comb begin
        w_bank_nx    = r_bank_st;
        w_oldest_nx  = r_oldest;
        w_cap_nx     = r_capturing;
        w_fill_nx    = r_fill_bank;
        w_ovr_nx     = r_overrun;
        w_rd_st_nx   = r_rd_st;
        w_rd_addr_nx = r_rd_addr;
        w_rd_bank_nx = r_rd_bank;
        w_issue      = 1'b0;
        w_iss_addr   = r_rd_addr;
        w_iss_bank   = r_rd_bank;
        w_avail[0]   = (r_bank_st[0] == EMPTY);
        w_avail[1]   = (r_bank_st[1] == EMPTY);

        unique case (r_rd_st)
            RD_IDLE: begin
                if (w_room && (r_bank_st[0] == FULL || r_bank_st[1] == FULL)) begin
                    w_iss_bank            = (r_bank_st[r_oldest] == FULL) ? r_oldest : ~r_oldest;
                    w_bank_nx[w_iss_bank] = READING;
                    w_rd_bank_nx          = w_iss_bank;
                    w_issue               = 1'b1;
                    w_iss_addr            = '0;
                    w_rd_addr_nx          = ADDR_W'(1);
                    w_rd_st_nx            = RD_RUN;
                end
            end
            RD_RUN: begin
                if (w_room) begin
                    w_issue = 1'b1;
                    if (r_rd_addr == LAST_ADDR) begin
                        w_bank_nx[r_rd_bank] = EMPTY;
                        if (r_bank_st[~r_rd_bank] == FULL) w_oldest_nx = ~r_rd_bank;
                        w_rd_st_nx = RD_IDLE;
                    end else begin
                        w_rd_addr_nx = r_rd_addr + 1'b1;
                    end
                end
            end
            default: ;
        endcase

        if (w_fd) begin
            w_bank_nx[r_fill_bank] = FULL;
            w_cap_nx               = 1'b0;
            if (r_bank_st[~r_fill_bank] != FULL) w_oldest_nx = r_fill_bank;
        end

        // core decided on the registered doing flag, so arming must follow it
        // even if a bank is freed by an overrun in this very cycle.
        if (bus.core_end) begin
            if (r_capturing && !w_fd) begin
                w_bank_nx[r_fill_bank] = EMPTY;
                w_ovr_nx               = 1'b1;
                w_avail[r_fill_bank]   = 1'b1;
            end
            w_cap_nx = 1'b0;
            if (r_doing && (w_avail[0] || w_avail[1])) begin
                w_fill_nx            = w_avail[0] ? 1'b0 : 1'b1;
                w_bank_nx[w_fill_nx] = FILLING;
                w_cap_nx             = 1'b1;
            end
        end
    end

    always_ff @(posedge clk24 or posedge rst) begin
        if (rst) begin
            r_bank_st[0] <= EMPTY;
            r_bank_st[1] <= EMPTY;
            r_oldest     <= 1'b0;
            r_capturing  <= 1'b0;
            r_fill_bank  <= 1'b0;
            r_overrun    <= 1'b0;
            r_doing      <= 1'b0;
            r_rd_st      <= RD_IDLE;
            r_rd_addr    <= '0;
            r_rd_bank    <= 1'b0;
        end else begin
            r_bank_st    <= w_bank_nx;
            r_oldest     <= w_oldest_nx;
            r_capturing  <= w_cap_nx;
            r_fill_bank  <= w_fill_nx;
            r_overrun    <= w_ovr_nx;
            r_doing      <= (r_bank_st[0] == EMPTY) || (r_bank_st[1] == EMPTY);
            r_rd_st      <= w_rd_st_nx;
            r_rd_addr    <= w_rd_addr_nx;
            r_rd_bank    <= w_rd_bank_nx;
        end
    end

    lenet_buf_ram #(
        .DEPTH (2 * NPIX),
        .AW    (ADDR_W + 1),
        .DW    (8)
    ) u_ram (
        .i_clk   (clk24),
        .i_we    (w_we),
        .i_waddr ({r_fill_bank, bus.wr_addr}),
        .i_wdata (bus.wr_data),
        .i_re    (w_issue),
        .i_raddr ({w_iss_bank, w_iss_addr}),
        .o_rdata (w_ram_q)
    );

    // p1: border/last flags travel with the registered RAM read
    always_ff @(posedge clk24 or posedge rst) begin
        if (rst) begin
            r_vld_p1  <= 1'b0;
            r_pad_p1  <= 1'b0;
            r_last_p1 <= 1'b0;
        end else begin
            r_vld_p1 <= w_issue;
            if (w_issue) begin
                r_pad_p1  <= is_border(w_iss_addr);
                r_last_p1 <= (w_iss_addr == LAST_ADDR);
            end
        end
    end

    assign w_px_p1 = r_pad_p1 ? PAD_VALUE : w_ram_q;

    // Two-entry skid, entry 0 is the head presented on the stream.
    always_ff @(posedge clk24 or posedge rst) begin
        if (rst) begin
            r_sk_cnt <= 2'd0;
            r_sk_d[0] <= 8'h00;
            r_sk_d[1] <= 8'h00;
            r_sk_l[0] <= 1'b0;
            r_sk_l[1] <= 1'b0;
        end else begin
            unique case ({w_push, w_pop})
                2'b10: begin
                    if (r_sk_cnt == 2'd0) begin
                        r_sk_d[0] <= w_px_p1;
                        r_sk_l[0] <= r_last_p1;
                    end else begin
                        r_sk_d[1] <= w_px_p1;
                        r_sk_l[1] <= r_last_p1;
                    end
                    r_sk_cnt <= r_sk_cnt + 2'd1;
                end
                2'b01: begin
                    r_sk_d[0] <= r_sk_d[1];
                    r_sk_l[0] <= r_sk_l[1];
                    r_sk_cnt  <= r_sk_cnt - 2'd1;
                end
                2'b11: begin
                    if (r_sk_cnt == 2'd1) begin
                        r_sk_d[0] <= w_px_p1;
                        r_sk_l[0] <= r_last_p1;
                    end else begin
                        r_sk_d[0] <= r_sk_d[1];
                        r_sk_l[0] <= r_sk_l[1];
                        r_sk_d[1] <= w_px_p1;
                        r_sk_l[1] <= r_last_p1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.m_valid            = (r_sk_cnt != 2'd0);
    assign bus.m_data             = r_sk_d[0];
    assign bus.m_last             = r_sk_l[0];
    assign bus.lenet_doing_signal = r_doing;
    assign bus.overrun            = r_overrun;
endmodule
